// File: rtl/ss_console_pkg.sv
// ss_console_pkg: shared constants, state type and sizing helper for the console arbiter.
package ss_console_pkg;

    localparam logic [7:0] EOL_DEFAULT = 8'h0A;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    // Idle counter only needs to hold 0..timeout-1.
    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/ss_rr_pick.sv
// ss_rr_pick: combinational round-robin selector; first set request searching upward from ptr+1 with wrap.
module ss_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] k;

    // Walk from farthest to nearest so the nearest candidate overwrites last.
    always_comb begin
        idx = '0;
        k   = '0;
        for (int i = N; i >= 1; i--) begin
            k = W'((int'(ptr) + i) % N);
            if (req[k]) idx = k;
        end
    end

    assign any = |req;

endmodule

// File: rtl/ss_console_arbiter.sv
// ss_console_arbiter: message-granular round-robin sharing of one console byte channel.
// A granted requester owns the channel until it sends EOL_CHAR or stays idle for IDLE_TIMEOUT cycles.
module ss_console_arbiter
    import ss_console_pkg::*;
#(
    parameter int         NUM_REQ      = 4,
    parameter int         IDLE_TIMEOUT = 256,
    parameter logic [7:0] EOL_CHAR     = EOL_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic [NUM_REQ*8-1:0]       req_data_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [7:0]                 tx_data_o,
    output logic                       tx_valid_o,
    input  logic                       tx_ready_i,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int W  = $clog2(NUM_REQ);
    localparam int CW = cnt_width(IDLE_TIMEOUT);

    state_t        state, state_n;
    logic [W-1:0]  ptr, gnt;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    data_arr [NUM_REQ];
    logic [7:0]    own_data;
    logic          any, locked, out_free, own_valid, xfer, expire, release_now;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data_i[g*8 +: 8];
    end

    ss_rr_pick #(.N(NUM_REQ), .W(W)) u_pick (
        .req (req_valid_i),
        .ptr (ptr),
        .idx (gnt),
        .any (any)
    );

    assign locked    = (state == LOCKED);
    assign out_free  = !tx_valid_o || tx_ready_i;
    assign own_valid = req_valid_i[owner_o];
    assign own_data  = data_arr[owner_o];
    assign xfer      = locked && own_valid && out_free;
    // Timeout only advances while the owner has nothing to offer; backpressure holds it.
    assign expire    = locked && !own_valid && (cnt == CW'(IDLE_TIMEOUT - 1));
    assign release_now = (xfer && own_data == EOL_CHAR) || expire;

    assign req_ready_o = (locked && out_free) ? (NUM_REQ'(1) << owner_o) : '0;
    assign busy_o      = locked;

    always_comb begin
        state_n = state;
        cnt_n   = (!locked || xfer || expire) ? '0 : (own_valid ? cnt : cnt + CW'(1));
        if (state == IDLE) state_n = any ? LOCKED : IDLE;
        else state_n = release_now ? IDLE : LOCKED;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ptr        <= W'(NUM_REQ - 1);
            owner_o    <= '0;
            cnt        <= '0;
            timeout_o  <= 1'b0;
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
        end else begin
            cnt       <= cnt_n;
            timeout_o <= expire;
            if (!locked && any) owner_o <= gnt;
            if (locked && release_now) ptr <= owner_o;
            if (xfer) begin
                tx_data_o  <= own_data;
                tx_valid_o <= 1'b1;
            end else if (tx_ready_i) begin
                tx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ss_console_arbiter.sv
// tb_ss_console_arbiter: scripted/random requesters with a per-requester byte scoreboard and message-contiguity model.
module tb_ss_console_arbiter;

    localparam int         N   = 4;
    localparam int         TO  = 16;
    localparam logic [7:0] EOL = 8'h0A;

    logic           clk = 1'b0;
    logic           arst;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [1:0]     owner;
    logic           busy;
    logic           timeout;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int tmo_cnt = 0;
    int tmo_cyc = 0;
    int open_src = -1;
    int last_acc [N];
    bit acc [N];
    bit rand_ready = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    logic [7:0] byt_q [N][$];
    int         pre_q [N][$];
    logic [7:0] exp_q [N][$];
    int         pend [$];
    int         log_src [$];
    logic [7:0] log_b [$];
    int         log_cyc [$];

    always #5 clk = ~clk;

    ss_console_arbiter #(.NUM_REQ(N), .IDLE_TIMEOUT(TO), .EOL_CHAR(EOL)) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .req_data_i  (req_data),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .owner_o     (owner),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    task automatic push(input int k, input logic [7:0] b, input int pre);
        byt_q[k].push_back(b);
        pre_q[k].push_back(pre);
        exp_q[k].push_back(b);
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) begin
            byt_q[k].delete();
            pre_q[k].delete();
            exp_q[k].delete();
        end
        pend.delete();
        open_src = -1;
        prev_stall = 1'b0;
        req_valid = '0;
        req_data = '0;
    endtask

    task automatic clear_log();
        log_src.delete();
        log_b.delete();
        log_cyc.delete();
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid[k] = 1'b0;
            req_data[k*8 +: 8] = 8'h00;
            if (byt_q[k].size() > 0) begin
                if (pre_q[k][0] > 0) begin
                    pre_q[k][0] = pre_q[k][0] - 1;
                end else begin
                    req_valid[k] = 1'b1;
                    req_data[k*8 +: 8] = byt_q[k][0];
                end
            end
        end
        if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    endtask

    // One clock: observe at negedge, then apply pops and new drive just after posedge.
    task automatic step();
        @(negedge clk);
        if (prev_stall) begin
            compared++;
            if (!tx_valid || tx_data !== prev_data) begin
                mismatched++;
                $display("FAIL tx_hold: valid=%0b data=%h required valid=1 data=%h", tx_valid, tx_data, prev_data);
            end
        end
        if (tx_valid && tx_ready) begin
            int s;
            logic [7:0] e;
            s = -1;
            if (pend.size() > 0) s = pend.pop_front();
            compared++;
            if (s < 0 || exp_q[s].size() == 0) begin
                mismatched++;
                $display("FAIL tx_extra: data=%h required no output", tx_data);
            end else begin
                e = exp_q[s].pop_front();
                if (tx_data !== e) begin
                    mismatched++;
                    $display("FAIL tx_data: src=%0d got=%h required=%h", s, tx_data, e);
                end
                compared++;
                if (open_src >= 0 && s != open_src) begin
                    mismatched++;
                    $display("FAIL tx_interleave: src=%0d required src=%0d", s, open_src);
                end
                open_src = (e == EOL) ? -1 : s;
                log_src.push_back(s);
                log_b.push_back(tx_data);
                log_cyc.push_back(cyc);
            end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data = tx_data;
        if (timeout) begin
            tmo_cnt++;
            tmo_cyc = cyc;
            open_src = -1;
        end
        compared++;
        if (!$onehot0(req_ready) || (req_ready != 0 && !busy)) begin
            mismatched++;
            $display("FAIL ready_gate: ready=%b busy=%0b required onehot0 and only while busy", req_ready, busy);
        end
        for (int k = 0; k < N; k++) begin
            acc[k] = req_valid[k] && req_ready[k];
            if (acc[k]) begin
                pend.push_back(k);
                last_acc[k] = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                void'(byt_q[k].pop_front());
                void'(pre_q[k].pop_front());
            end
        end
        drive();
    endtask

    function automatic bit all_done();
        for (int k = 0; k < N; k++) if (exp_q[k].size() != 0) return 1'b0;
        return pend.size() == 0 && !tx_valid;
    endfunction

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (n < budget && !all_done()) begin
            step();
            n++;
        end
        compared++;
        if (!all_done()) begin
            mismatched++;
            $display("FAIL drain_%s: %0d bytes outstanding after %0d cycles, required 0", name, pend.size(), budget);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        arst = 1'b1;
        tx_ready = 1'b1;
        req_valid = '1;
        req_data = '1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (tx_valid !== 1'b0) begin mismatched++; $display("FAIL rst_tx_valid: got=%0b required=0", tx_valid); end
        compared++;
        if (tx_data !== 8'h00) begin mismatched++; $display("FAIL rst_tx_data: got=%h required=00", tx_data); end
        compared++;
        if (owner !== 2'd0) begin mismatched++; $display("FAIL rst_owner: got=%0d required=0", owner); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got=%0b required=0", busy); end
        compared++;
        if (timeout !== 1'b0) begin mismatched++; $display("FAIL rst_timeout: got=%0b required=0", timeout); end
        compared++;
        if (req_ready !== '0) begin mismatched++; $display("FAIL rst_ready: got=%b required=0000", req_ready); end
        clear_all();
        arst = 1'b0;
        push(0, 8'h5A, 0);
        push(0, EOL, 0);
        drain(100, "warmup");
        for (int i = 0; i < 7; i++) push(0, 8'(8'h61 + i), 0);
        while (n < 50 && byt_q[0].size() > 4) begin
            step();
            n++;
        end
        compared++;
        if (byt_q[0].size() != 4 || tx_valid !== 1'b1 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_premsg: left=%0d valid=%0b busy=%0b required left=4 valid=1 busy=1", byt_q[0].size(), tx_valid, busy);
        end
        #2 arst = 1'b1;
        #1;
        compared++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_async: valid=%0b busy=%0b required 0 0", tx_valid, busy);
        end
        clear_all();
        @(posedge clk);
        #1 arst = 1'b0;
    endtask

    task automatic test_round_robin();
        clear_log();
        for (int k = 0; k < N; k++) begin
            push(k, 8'h41, 0);
            push(k, EOL, 0);
        end
        drain(200, "rr");
        compared++;
        if (log_src.size() != 8) begin
            mismatched++;
            $display("FAIL rr_count: got=%0d required=8", log_src.size());
        end
        for (int i = 0; i < 8 && i < log_src.size(); i++) begin
            compared++;
            if (log_src[i] != i / 2 || log_b[i] !== ((i % 2 == 0) ? 8'h41 : EOL)) begin
                mismatched++;
                $display("FAIL rr_order[%0d]: src=%0d byte=%h required src=%0d byte=%h", i, log_src[i], log_b[i], i / 2, (i % 2 == 0) ? 8'h41 : EOL);
            end
            if (i > 0) begin
                compared++;
                if (log_cyc[i] - log_cyc[i-1] != ((i % 2 == 1) ? 1 : 2)) begin
                    mismatched++;
                    $display("FAIL rr_gap[%0d]: got=%0d required=%0d", i, log_cyc[i] - log_cyc[i-1], (i % 2 == 1) ? 1 : 2);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int t0 = tmo_cnt;
        int exp_src [4] = '{1, 1, 2, 2};
        clear_log();
        push(1, 8'h68, 0);
        push(1, 8'h69, 0);
        push(2, 8'h42, 0);
        push(2, EOL, 0);
        drain(200, "timeout");
        compared++;
        if (tmo_cnt - t0 != 1) begin mismatched++; $display("FAIL tmo_pulses: got=%0d required=1", tmo_cnt - t0); end
        compared++;
        if (tmo_cyc - last_acc[1] != TO + 1) begin
            mismatched++;
            $display("FAIL tmo_latency: got=%0d required=%0d", tmo_cyc - last_acc[1], TO + 1);
        end
        compared++;
        if (owner !== 2'd2) begin mismatched++; $display("FAIL tmo_owner: got=%0d required=2", owner); end
        compared++;
        if (log_src.size() != 4) begin mismatched++; $display("FAIL tmo_count: got=%0d required=4", log_src.size()); end
        for (int i = 0; i < 4 && i < log_src.size(); i++) begin
            compared++;
            if (log_src[i] != exp_src[i]) begin
                mismatched++;
                $display("FAIL tmo_src[%0d]: got=%0d required=%0d", i, log_src[i], exp_src[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int t0 = tmo_cnt;
        logic [7:0] msg [4] = '{8'h58, 8'h59, 8'h5A, EOL};
        clear_log();
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(3, msg[i], 0);
        repeat (1000) step();
        compared++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h58) begin
            mismatched++;
            $display("FAIL bp_hold: valid=%0b data=%h required 1 58", tx_valid, tx_data);
        end
        compared++;
        if (req_ready !== '0) begin mismatched++; $display("FAIL bp_ready: got=%b required=0000", req_ready); end
        compared++;
        if (busy !== 1'b1 || owner !== 2'd3) begin
            mismatched++;
            $display("FAIL bp_lock: busy=%0b owner=%0d required 1 3", busy, owner);
        end
        compared++;
        if (tmo_cnt != t0) begin mismatched++; $display("FAIL bp_timeout: got=%0d required=0", tmo_cnt - t0); end
        tx_ready = 1'b1;
        drain(100, "bp");
        compared++;
        if (log_src.size() != 4) begin mismatched++; $display("FAIL bp_count: got=%0d required=4", log_src.size()); end
        for (int i = 0; i < 4 && i < log_src.size(); i++) begin
            compared++;
            if (log_src[i] != 3 || log_b[i] !== msg[i]) begin
                mismatched++;
                $display("FAIL bp_order[%0d]: src=%0d byte=%h required src=3 byte=%h", i, log_src[i], log_b[i], msg[i]);
            end
        end
    endtask

    task automatic test_eol_threshold();
        int t0 = tmo_cnt;
        tx_ready = 1'b1;
        push(0, 8'h51, 0);
        push(0, EOL, TO - 1);
        drain(200, "eol_edge");
        compared++;
        if (tmo_cnt != t0) begin mismatched++; $display("FAIL eol_edge_timeout: got=%0d required=0", tmo_cnt - t0); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL eol_edge_busy: got=%0b required=0", busy); end
        t0 = tmo_cnt;
        push(0, 8'h52, 0);
        push(0, EOL, TO);
        drain(200, "eol_late");
        compared++;
        if (tmo_cnt - t0 != 1) begin mismatched++; $display("FAIL eol_late_timeout: got=%0d required=1", tmo_cnt - t0); end
    endtask

    task automatic test_random();
        int t0 = tmo_cnt;
        logic [7:0] b;
        for (int r = 0; r < 2; r++) begin
            rand_ready = 1'b1;
            for (int k = 0; k < N; k++) begin
                for (int m = 0; m < 3; m++) begin
                    int len = $urandom_range(1, 5);
                    for (int j = 0; j < len; j++) begin
                        b = 8'($urandom_range(0, 255));
                        if (b == EOL) b = 8'h41;
                        push(k, b, $urandom_range(0, 3));
                    end
                    push(k, EOL, $urandom_range(0, 3));
                end
            end
            drain(3000, "random");
            rand_ready = 1'b0;
            tx_ready = 1'b1;
        end
        compared++;
        if (tmo_cnt != t0) begin mismatched++; $display("FAIL rand_timeout: got=%0d required=0", tmo_cnt - t0); end
    endtask

    initial begin
        for (int k = 0; k < N; k++) last_acc[k] = 0;
        test_reset();
        test_round_robin();
        test_timeout();
        test_backpressure();
        test_eol_threshold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
